// File: rtl/dual_core_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_core_mem_arbiter_pkg
// Brief    : Shared state encoding and default widths for the memory arbiter.
// Revision : 1.0
// ============================================================================
package dual_core_mem_arbiter_pkg;

    localparam int c_def_aw    = 32;
    localparam int c_def_dw    = 32;
    localparam int c_def_cnt_w = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dual_core_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dual_core_mem_arbiter_if
// Brief    : One-word memory request port; the requester uses master, the
//            responder uses slave.
// Revision : 1.0
// ============================================================================
interface dual_core_mem_arbiter_if
    import dual_core_mem_arbiter_pkg::*;
#(
    parameter int AW = c_def_aw,
    parameter int DW = c_def_dw
);
    logic          acc;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rdy;
    logic [DW-1:0] q;

    modport master (output acc, wr, a, d, input rdy, q);
    modport slave  (input acc, wr, a, d, output rdy, q);
endinterface
`default_nettype wire

// File: rtl/dual_core_mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational 2-way round-robin pick; a tie goes to the core that
//            was not served last.
// Revision : 1.0
// ============================================================================
module rr_pick2 (
    input  wire logic [1:0] req,
    input  wire logic       last,
    output logic            grant,
    output logic            valid
);
    assign valid = |req;
    assign grant = (&req) ? ~last : req[1];
endmodule
`default_nettype wire

// File: rtl/dual_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dual_core_mem_arbiter
// Brief    : Round-robin arbiter of one shared memory bus between two cores,
//            with saturating per-core completion counters.
// Revision : 1.0
// ============================================================================
module dual_core_mem_arbiter
    import dual_core_mem_arbiter_pkg::*;
#(
    parameter int AW    = c_def_aw,
    parameter int DW    = c_def_dw,
    parameter int CNT_W = c_def_cnt_w
) (
    input  wire logic               clk,
    input  wire logic               rst,
    dual_core_mem_arbiter_if.slave  core0,
    dual_core_mem_arbiter_if.slave  core1,
    dual_core_mem_arbiter_if.master mem,
    output logic                    owner,
    output logic                    busy,
    output logic [CNT_W-1:0]        cnt0,
    output logic [CNT_W-1:0]        cnt1
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_owner;
    logic             w_owner_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic             w_inc0;
    logic             w_inc1;

    logic             w_pick_grant;
    logic             w_pick_valid;
    logic             w_busy;
    logic             w_own_acc;
    logic             w_own_wr;
    logic [AW-1:0]    w_own_a;
    logic [DW-1:0]    w_own_d;
    logic             w_done;

    rr_pick2 u_pick (
        .req   ({core1.acc, core0.acc}),
        .last  (r_last),
        .grant (w_pick_grant),
        .valid (w_pick_valid)
    );

    assign w_busy    = (r_state == ST_BUSY);
    assign w_own_acc = r_owner ? core1.acc : core0.acc;
    assign w_own_wr  = r_owner ? core1.wr  : core0.wr;
    assign w_own_a   = r_owner ? core1.a   : core0.a;
    assign w_own_d   = r_owner ? core1.d   : core0.d;

    // A reset landing with m_ready drops the transaction, so no rdy is shown.
    assign w_done = w_busy & w_own_acc & mem.rdy & ~rst;

    assign mem.acc = w_busy & w_own_acc;
    assign mem.wr  = w_busy & w_own_wr;
    assign mem.a   = w_busy ? w_own_a : '0;
    assign mem.d   = w_busy ? w_own_d : '0;

    assign core0.rdy = w_done & ~r_owner;
    assign core1.rdy = w_done &  r_owner;
    assign core0.q   = core0.rdy ? mem.q : '0;
    assign core1.q   = core1.rdy ? mem.q : '0;

    assign owner = r_owner;
    assign busy  = w_busy;
    assign cnt0  = r_cnt0;
    assign cnt1  = r_cnt1;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_inc0      = 1'b0;
        w_inc1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_owner_nxt = w_pick_grant;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Dropping acc wins over a simultaneous m_ready.
                if (!w_own_acc) begin
                    w_state_nxt = ST_IDLE;
                end else if (mem.rdy) begin
                    w_state_nxt = ST_GAP;
                    w_last_nxt  = r_owner;
                    w_inc0      = ~r_owner;
                    w_inc1      =  r_owner;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            if (w_inc0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_inc1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

endmodule
`default_nettype wire
